// File: rtl/ifu_pkg.sv
// Shared types for the IFU instruction-memory fill path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifu_pkg;

    localparam int CL_WIDTH        = 128;
    localparam int IMEM_FILL_BEATS = CL_WIDTH / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } t_imem_fill_state;

    // Fill request from the instruction cache: a miss address plus a strobe.
    typedef struct packed {
        logic        fill_requested_address_valid;
        logic [31:0] fill_requested_address;
    } t_cache2i_mem_req;

    // Filled line returned to the instruction cache.
    typedef struct packed {
        logic                valid;
        logic [31:0]         address;
        logic [CL_WIDTH-1:0] filled_instruction;
    } t_i_mem2cache_rsp;

endpackage

// File: rtl/ifu_fill_req_fifo.sv
// Fill-request queue: power-of-2 circular buffer of request addresses.
// Latency: pushed entry visible on head_data the cycle after the push edge.
// Backpressure: none internally; push is ignored when full unless popping the same cycle.
//
// Ports: Clk/RstN clock and async active-low reset; push/push_data enqueue;
// pop dequeues the head; full/empty/count occupancy; head_data oldest entry.
module ifu_fill_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     Clk,
    input  logic                     RstN,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_imem_fill_rsp.sv
// Instruction-memory fill responder: queues cache fill requests, reads 4 SRAM words, returns one line.
// Latency: request accepted at T into an idle block -> response valid at T+6+SRAM_RD_LATENCY.
// Backpressure: none toward the cache; a request arriving to a full queue is dropped and FillOverflow sticks.
//
// Ports: Clk/RstN clock and async active-low reset; Cache2IMemReq fill request in;
// IMem2CacheRsp one-cycle line response; SramRdEn/SramRdAddr/SramRdData SRAM read port;
// FillOverflow sticky drop flag. Optional macro IFU_FILL_CRITICAL_WORD_FIRST_EN starts
// each fill at the requested word and wraps; response content and timing are unchanged.
module ifu_imem_fill_rsp
    import ifu_pkg::*;
#(
    parameter int SRAM_RD_LATENCY = 1,
    parameter int REQ_Q_DEPTH     = 2,
    parameter int IMEM_ADDR_W     = 14
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  t_cache2i_mem_req       Cache2IMemReq,
    output t_i_mem2cache_rsp       IMem2CacheRsp,
    output logic                   SramRdEn,
    output logic [IMEM_ADDR_W-1:0] SramRdAddr,
    input  logic [31:0]            SramRdData,
    output logic                   FillOverflow
);

    localparam int QCW = $clog2(REQ_Q_DEPTH) + 1;

    t_imem_fill_state    state;
    t_imem_fill_state    state_nxt;
    logic [31:0]         head_addr;
    logic                q_full;
    logic                q_empty;
    logic [QCW-1:0]      q_count;
    logic                push;
    logic                pop;
    logic                drop;
    logic [1:0]          beat_cnt;
    logic [1:0]          beat_ofs;
    logic [1:0]          cap_cnt;
    logic                pipe_vld  [SRAM_RD_LATENCY];
    logic [1:0]          pipe_slot [SRAM_RD_LATENCY];
    logic                cap_vld;
    logic [1:0]          cap_slot;
    logic [CL_WIDTH-1:0] line_q;
    logic                unused_addr_bits;

    // Head leaves the queue in the single response cycle.
    assign pop  = (state == RSP);
    assign push = Cache2IMemReq.fill_requested_address_valid && (!q_full || pop);
    assign drop = Cache2IMemReq.fill_requested_address_valid && q_full && !pop;

    ifu_fill_req_fifo #(
        .DEPTH (REQ_Q_DEPTH),
        .WIDTH (32)
    ) u_req_fifo (
        .Clk       (Clk),
        .RstN      (RstN),
        .push      (push),
        .push_data (Cache2IMemReq.fill_requested_address),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head_data (head_addr)
    );

    // Byte offset within a word never matters; sub-line bits only matter for word ordering.
    assign unused_addr_bits = ^head_addr[3:0];

`ifdef IFU_FILL_CRITICAL_WORD_FIRST_EN
    assign beat_ofs = head_addr[3:2] + beat_cnt;
`else
    assign beat_ofs = beat_cnt;
`endif

    // The word offset of each beat travels alongside the read so the returning
    // data lands in the right slot whatever order the beats were issued in.
    assign cap_vld  = pipe_vld[SRAM_RD_LATENCY-1];
    assign cap_slot = pipe_slot[SRAM_RD_LATENCY-1];

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!q_empty) state_nxt = READ;
            READ: if (beat_cnt == 2'd3) state_nxt = WAIT;
            WAIT: if (cap_vld && cap_cnt == 2'd3) state_nxt = RSP;
            // q_count still includes the head being popped this cycle.
            RSP:  state_nxt = (q_count > QCW'(1) || push) ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        IMem2CacheRsp = '0;
        SramRdEn      = 1'b0;
        SramRdAddr    = '0;
        if (state == READ) begin
            SramRdEn   = 1'b1;
            SramRdAddr = {head_addr[IMEM_ADDR_W+1:4], beat_ofs};
        end
        if (state == RSP) begin
            IMem2CacheRsp.valid              = 1'b1;
            IMem2CacheRsp.address            = {head_addr[31:4], 4'h0};
            IMem2CacheRsp.filled_instruction = line_q;
        end
    end

    // Beat and capture counters wrap to zero after four, ready for the next line.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            beat_cnt <= 2'd0;
            cap_cnt  <= 2'd0;
        end else begin
            if (state == READ) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
            if (cap_vld) begin
                cap_cnt <= cap_cnt + 2'd1;
            end
        end
    end

    // Reset clears the pipe, so words in flight at reset are never captured.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            for (int i = 0; i < SRAM_RD_LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_slot[i] <= 2'd0;
            end
        end else begin
            pipe_vld[0]  <= SramRdEn;
            pipe_slot[0] <= beat_ofs;
            for (int i = 1; i < SRAM_RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_slot[i] <= pipe_slot[i-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            line_q <= '0;
        end else if (cap_vld) begin
            for (int k = 0; k < IMEM_FILL_BEATS; k++) begin
                if (cap_slot == 2'(k)) begin
                    line_q[32*k +: 32] <= SramRdData;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            FillOverflow <= 1'b0;
        end else if (drop) begin
            FillOverflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_imem_fill_rsp.sv
// Bench for ifu_imem_fill_rsp: directed scenarios plus randomized traffic and resets.
// Expected responses, SRAM read strobes/addresses and the overflow flag come from a
// queue-based model that derives each request's response cycle arithmetically.
module tb_ifu_imem_fill_rsp;
    import ifu_pkg::*;

    localparam int L     = 1;
    localparam int DEPTH = 2;
    localparam int AW    = 14;

    logic             Clk;
    logic             RstN;
    t_cache2i_mem_req req;
    t_i_mem2cache_rsp rsp;
    logic             SramRdEn;
    logic [AW-1:0]    SramRdAddr;
    logic [31:0]      SramRdData;
    logic             FillOverflow;

    ifu_imem_fill_rsp #(
        .SRAM_RD_LATENCY (L),
        .REQ_Q_DEPTH     (DEPTH),
        .IMEM_ADDR_W     (AW)
    ) dut (
        .Clk           (Clk),
        .RstN          (RstN),
        .Cache2IMemReq (req),
        .IMem2CacheRsp (rsp),
        .SramRdEn      (SramRdEn),
        .SramRdAddr    (SramRdAddr),
        .SramRdData    (SramRdData),
        .FillOverflow  (FillOverflow)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        int          t;
        int          rsp;
        logic [31:0] a;
    } ent_t;

    int            checks;
    int            failures;
    int            cyc;
    int            last_rsp;
    logic          ovf_exp;
    ent_t          pend[$];
    logic [31:0]   mem [1 << AW];
    logic          dl_en   [L+1];
    logic [AW-1:0] dl_addr [L+1];

    int             rsp_cyc_log[$];
    logic [31:0]    rsp_addr_log[$];
    logic [127:0]   rsp_line_log[$];
    int             rd_cyc_log[$];
    logic [AW-1:0]  rd_addr_log[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] word_addr(input logic [31:0] a, input int k);
        logic [1:0] kk;
        kk = 2'(k);
        return {a[AW+1:4], kk};
    endfunction

    task automatic clear_logs();
        rsp_cyc_log.delete();
        rsp_addr_log.delete();
        rsp_line_log.delete();
        rd_cyc_log.delete();
        rd_addr_log.delete();
    endtask

    task automatic model_reset();
        pend.delete();
        last_rsp = -100;
        ovf_exp  = 1'b0;
        for (int i = 0; i <= L; i++) begin
            dl_en[i]   = 1'b0;
            dl_addr[i] = '0;
        end
    endtask

    // Occupancy at cycle n is the set of accepted requests not yet answered by n;
    // one answered exactly at n frees its slot in that same cycle.
    task automatic model_offer(input int n, input logic [31:0] a);
        ent_t e;
        if (pend.size() < DEPTH) begin
            e.t   = n;
            e.a   = a;
            e.rsp = (n > last_rsp) ? n + 6 + L : last_rsp + 5 + L;
            last_rsp = e.rsp;
            pend.push_back(e);
        end else begin
            ovf_exp = 1'b1;
        end
    endtask

    task automatic check_cycle();
        logic          ev;
        logic [31:0]   ea;
        logic [127:0]  el;
        logic          ee;
        logic [AW-1:0] era;
        logic [1:0]    st;
        int            s;
        ev = 1'b0; ea = '0; el = '0; ee = 1'b0; era = '0;
        foreach (pend[i]) begin
            if (pend[i].rsp == cyc) begin
                ev = 1'b1;
                ea = {pend[i].a[31:4], 4'h0};
                for (int k = 0; k < 4; k++) el[32*k +: 32] = mem[word_addr(pend[i].a, k)];
            end
            s = pend[i].rsp - 4 - L;
            if (cyc >= s && cyc <= s + 3) begin
`ifdef IFU_FILL_CRITICAL_WORD_FIRST_EN
                st = pend[i].a[3:2];
`else
                st = 2'd0;
`endif
                ee  = 1'b1;
                era = word_addr(pend[i].a, (int'(st) + cyc - s) % 4);
            end
        end
        chk("rsp_valid", rsp.valid, ev);
        chk("rsp_addr", rsp.address, ea);
        chk("rsp_line", rsp.filled_instruction, el);
        chk("rd_en", SramRdEn, ee);
        chk("rd_addr", SramRdAddr, era);
        chk("overflow", FillOverflow, ovf_exp);
        if (rsp.valid) begin
            rsp_cyc_log.push_back(cyc);
            rsp_addr_log.push_back(rsp.address);
            rsp_line_log.push_back(rsp.filled_instruction);
        end
        if (SramRdEn) begin
            rd_cyc_log.push_back(cyc);
            rd_addr_log.push_back(SramRdAddr);
        end
        while (pend.size() > 0 && pend[0].rsp <= cyc) void'(pend.pop_front());
    endtask

    // One cycle: check outputs of this cycle, drive SRAM data, then the request
    // (and reset level) that the closing clock edge will see.
    task automatic tick(input logic v, input logic [31:0] a, input logic rstn);
        @(negedge Clk);
        cyc++;
        check_cycle();
        for (int i = L; i > 0; i--) begin
            dl_en[i]   = dl_en[i-1];
            dl_addr[i] = dl_addr[i-1];
        end
        dl_en[0]   = SramRdEn;
        dl_addr[0] = SramRdAddr;
        SramRdData = dl_en[L] ? mem[dl_addr[L]] : $urandom();
        RstN = rstn;
        if (!rstn) model_reset();
        req.fill_requested_address_valid = v && rstn;
        req.fill_requested_address       = a;
        if (v && rstn) model_offer(cyc, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b1);
    endtask

    localparam logic [31:0]  WA = 32'h1111_AAAA;
    localparam logic [31:0]  WB = 32'h2222_BBBB;
    localparam logic [31:0]  WC = 32'h3333_CCCC;
    localparam logic [31:0]  WD = 32'h4444_DDDD;
    localparam logic [127:0] LINE_DCBA = {WD, WC, WB, WA};

    int t0;
    int t1;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        RstN = 1'b0;
        req = '0;
        SramRdData = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom();
        mem[14'h48C] = WA; mem[14'h48D] = WB; mem[14'h48E] = WC; mem[14'h48F] = WD;
        model_reset();

        // Reset state.
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        chk("reset_en", SramRdEn, 1'b0);
        chk("reset_valid", rsp.valid, 1'b0);
        chk("reset_ovf", FillOverflow, 1'b0);
        tick(1'b0, 32'h0, 1'b1);
        idle(2);

        // Single fill.
        clear_logs();
        tick(1'b1, 32'h0000_1234, 1'b1);
        t0 = cyc;
        idle(12);
        chk("single_cnt", rsp_cyc_log.size(), 1);
        chk("single_lat", rsp_cyc_log[0], t0 + 7);
        chk("single_addr", rsp_addr_log[0], 32'h0000_1230);
        chk("single_line", rsp_line_log[0], LINE_DCBA);

        // Fill with a non-zero starting word.
        clear_logs();
        tick(1'b1, 32'h0000_1238, 1'b1);
        t0 = cyc;
        idle(12);
        chk("cwf_lat", rsp_cyc_log[0], t0 + 7);
        chk("cwf_line", rsp_line_log[0], LINE_DCBA);
`ifdef IFU_FILL_CRITICAL_WORD_FIRST_EN
        chk("cwf_rd0", rd_addr_log[0], 14'h48E);
        chk("cwf_rd1", rd_addr_log[1], 14'h48F);
        chk("cwf_rd2", rd_addr_log[2], 14'h48C);
        chk("cwf_rd3", rd_addr_log[3], 14'h48D);
`else
        chk("cwf_rd0", rd_addr_log[0], 14'h48C);
        chk("cwf_rd1", rd_addr_log[1], 14'h48D);
        chk("cwf_rd2", rd_addr_log[2], 14'h48E);
        chk("cwf_rd3", rd_addr_log[3], 14'h48F);
`endif

        // Back-to-back.
        clear_logs();
        tick(1'b1, 32'h0000_0100, 1'b1);
        t0 = cyc;
        tick(1'b1, 32'h0000_0200, 1'b1);
        idle(20);
        chk("b2b_cnt", rsp_cyc_log.size(), 2);
        chk("b2b_lat0", rsp_cyc_log[0], t0 + 7);
        chk("b2b_lat1", rsp_cyc_log[1], t0 + 13);
        chk("b2b_addr0", rsp_addr_log[0], 32'h0000_0100);
        chk("b2b_addr1", rsp_addr_log[1], 32'h0000_0200);
        chk("b2b_beat", rd_cyc_log[4], rsp_cyc_log[0] + 1);

        // Overflow.
        clear_logs();
        tick(1'b1, 32'h0000_0300, 1'b1);
        tick(1'b1, 32'h0000_0400, 1'b1);
        tick(1'b1, 32'h0000_0500, 1'b1);
        idle(25);
        chk("ovf_flag", FillOverflow, 1'b1);
        chk("ovf_cnt", rsp_cyc_log.size(), 2);
        chk("ovf_addr0", rsp_addr_log[0], 32'h0000_0300);
        chk("ovf_addr1", rsp_addr_log[1], 32'h0000_0400);

        // Reset during WAIT.
        clear_logs();
        tick(1'b1, 32'h0000_0600, 1'b1);
        idle(5);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        chk("rstmid_valid", rsp.valid, 1'b0);
        chk("rstmid_en", SramRdEn, 1'b0);
        chk("rstmid_addr", SramRdAddr, '0);
        chk("rstmid_ovf", FillOverflow, 1'b0);
        tick(1'b1, 32'h0000_0700, 1'b1);
        t1 = cyc;
        idle(15);
        chk("rstmid_cnt", rsp_cyc_log.size(), 1);
        chk("rstmid_lat", rsp_cyc_log[0], t1 + 7);
        chk("rstmid_raddr", rsp_addr_log[0], 32'h0000_0700);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                tick(1'b0, 32'h0, 1'b0);
                tick(1'b0, 32'h0, 1'b0);
            end else begin
                tick($urandom_range(0, 99) < 30, $urandom(), 1'b1);
            end
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
